// File: rtl/vga_pkg.sv
// Shared VGA types: axis segment encoding, analyzer FSM states and the
// measured line timing record.
package vga_pkg;

  localparam int unsigned VGA_LINE_WIDTH = 12;

  typedef enum logic [1:0] {
    SYNC,
    BACKPORCH,
    ACTIVE,
    FRONTPORCH
  } VGA_state_e;

  typedef enum logic [2:0] {
    AN_ACQUIRE,
    AN_SYNC,
    AN_BACKPORCH,
    AN_ACTIVE,
    AN_FRONTPORCH
  } vga_analyzer_state_e;

  typedef struct packed {
    logic [VGA_LINE_WIDTH-1:0] visible_area;
    logic [VGA_LINE_WIDTH-1:0] front_porch;
    logic [VGA_LINE_WIDTH-1:0] sync_pulse;
    logic [VGA_LINE_WIDTH-1:0] back_porch;
    logic                      polarity;
  } line_timing_t;

  // ACQUIRE has no segment of its own and reports as SYNC.
  function automatic VGA_state_e vga_state_map(input vga_analyzer_state_e s);
    case (s)
      AN_BACKPORCH:  return BACKPORCH;
      AN_ACTIVE:     return ACTIVE;
      AN_FRONTPORCH: return FRONTPORCH;
      default:       return SYNC;
    endcase
  endfunction

endpackage

// File: rtl/vga_edge_sampler.sv
// Tick-gated input register for sync/de with previous-sample history and
// de edge detection.
module vga_edge_sampler (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync_in,
  input  logic de_in,
  output logic sync_cur,
  output logic sync_prev,
  output logic de_cur,
  output logic de_rise,
  output logic de_fall
);

  logic de_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_cur  <= 1'b0;
      sync_prev <= 1'b0;
      de_cur    <= 1'b0;
      de_prev   <= 1'b0;
    end else if (tick) begin
      sync_prev <= sync_cur;
      sync_cur  <= sync_in;
      de_prev   <= de_cur;
      de_cur    <= de_in;
    end
  end

  assign de_rise = de_cur & ~de_prev;
  assign de_fall = ~de_cur & de_prev;

endmodule

// File: rtl/vga_line_analyzer.sv
// Measures sync / back porch / visible / front porch lengths of one VGA axis,
// detects sync polarity and reports lock once periods repeat.
module vga_line_analyzer
  import vga_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 12,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  sync_in,
  input  logic                  de_in,
  output logic [LINE_WIDTH-1:0] visible_area,
  output logic [LINE_WIDTH-1:0] front_porch,
  output logic [LINE_WIDTH-1:0] sync_pulse,
  output logic [LINE_WIDTH-1:0] back_porch,
  output logic                  polarity,
  output VGA_state_e            state,
  output logic                  locked,
  output logic                  period_done,
  output logic                  error
);

  localparam logic [LINE_WIDTH-1:0] CNT_LAST = {{(LINE_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [3:0]            LOCK_THR = 4'(LOCK_COUNT);

  vga_analyzer_state_e st;
  logic [LINE_WIDTH-1:0] cnt_sync, cnt_bp, cnt_act, cnt_fp;
  logic [3:0] match_cnt, match_next;
  logic pol_valid;
  logic sync_cur, sync_prev, de_cur, de_rise, de_fall;
  logic sync_on, sync_was_on, viol, same_set;

  vga_edge_sampler u_sampler (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .sync_in  (sync_in),
    .de_in    (de_in),
    .sync_cur (sync_cur),
    .sync_prev(sync_prev),
    .de_cur   (de_cur),
    .de_rise  (de_rise),
    .de_fall  (de_fall)
  );

  assign sync_on     = (sync_cur == polarity);
  assign sync_was_on = (sync_prev == polarity);
  assign state       = vga_state_map(st);

  // A counter about to step onto all-ones counts as a violation, so the
  // saturation check only applies when the segment keeps counting.
  always_comb begin
    viol = 1'b0;
    case (st)
      AN_SYNC:       viol = sync_on && (de_cur || cnt_sync == CNT_LAST);
      AN_BACKPORCH:  viol = sync_on || (!de_rise && cnt_bp == CNT_LAST);
      AN_ACTIVE:     viol = sync_on || (!de_fall && cnt_act == CNT_LAST);
      AN_FRONTPORCH: viol = de_rise || (!sync_on && cnt_fp == CNT_LAST);
      default:       viol = 1'b0;
    endcase
  end

  always_comb begin
    same_set = ({cnt_act, cnt_fp, cnt_sync, cnt_bp} ==
                {visible_area, front_porch, sync_pulse, back_porch});
    if (!same_set)
      match_next = 4'd1;
    else if (match_cnt == 4'd15)
      match_next = 4'd15;
    else
      match_next = match_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    period_done <= 1'b0;
    error       <= 1'b0;
    if (rst) begin
      st           <= AN_ACQUIRE;
      cnt_sync     <= '0;
      cnt_bp       <= '0;
      cnt_act      <= '0;
      cnt_fp       <= '0;
      visible_area <= '0;
      front_porch  <= '0;
      sync_pulse   <= '0;
      back_porch   <= '0;
      polarity     <= 1'b0;
      pol_valid    <= 1'b0;
      match_cnt    <= '0;
      locked       <= 1'b0;
    end else if (tick) begin
      if (viol) begin
        error     <= 1'b1;
        locked    <= 1'b0;
        match_cnt <= '0;
        pol_valid <= 1'b0;
        st        <= AN_ACQUIRE;
      end else begin
        case (st)
          AN_ACQUIRE: begin
            if (de_cur) begin
              polarity  <= ~sync_cur;
              pol_valid <= 1'b1;
            end
            if (pol_valid && sync_on && !sync_was_on) begin
              st       <= AN_SYNC;
              cnt_sync <= LINE_WIDTH'(1);
              cnt_bp   <= '0;
              cnt_act  <= '0;
              cnt_fp   <= '0;
            end
          end
          AN_SYNC: begin
            if (sync_on) begin
              cnt_sync <= cnt_sync + 1'b1;
            end else if (de_rise) begin
              st      <= AN_ACTIVE;
              cnt_act <= LINE_WIDTH'(1);
            end else begin
              st     <= AN_BACKPORCH;
              cnt_bp <= LINE_WIDTH'(1);
            end
          end
          AN_BACKPORCH: begin
            if (de_rise) begin
              st      <= AN_ACTIVE;
              cnt_act <= LINE_WIDTH'(1);
            end else begin
              cnt_bp <= cnt_bp + 1'b1;
            end
          end
          AN_ACTIVE: begin
            if (de_fall) begin
              st     <= AN_FRONTPORCH;
              cnt_fp <= LINE_WIDTH'(1);
            end else begin
              cnt_act <= cnt_act + 1'b1;
            end
          end
          AN_FRONTPORCH: begin
            if (sync_on) begin
              visible_area <= cnt_act;
              front_porch  <= cnt_fp;
              sync_pulse   <= cnt_sync;
              back_porch   <= cnt_bp;
              period_done  <= 1'b1;
              match_cnt    <= match_next;
              locked       <= (match_next >= LOCK_THR);
              st           <= AN_SYNC;
              cnt_sync     <= LINE_WIDTH'(1);
              cnt_bp       <= '0;
              cnt_act      <= '0;
              cnt_fp       <= '0;
            end else begin
              cnt_fp <= cnt_fp + 1'b1;
            end
          end
          default: st <= AN_ACQUIRE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_line_analyzer.sv
// Self-checking bench for vga_line_analyzer: table of timing formats plus
// hand-written lock-change, violation and mid-period reset sequences.
module tb_vga_line_analyzer;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b1;
  logic sync_in = 1'b1;
  logic de_in = 1'b0;
  logic [11:0] visible_area, front_porch, sync_pulse, back_porch;
  logic polarity, locked, period_done, error;
  VGA_state_e state;

  vga_line_analyzer #(.LINE_WIDTH(12), .LOCK_COUNT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .sync_in     (sync_in),
    .de_in       (de_in),
    .visible_area(visible_area),
    .front_porch (front_porch),
    .sync_pulse  (sync_pulse),
    .back_porch  (back_porch),
    .polarity    (polarity),
    .state       (state),
    .locked      (locked),
    .period_done (period_done),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    line_timing_t t;
    logic         locked;
  } exp_t;

  typedef struct {
    logic        pol;
    int          s, b, a, f;
    int unsigned div;
    int          periods;
    logic [11:0] e_va, e_fp, e_sp, e_bp;
    logic        e_pol;
    logic        e_lock;
  } vec_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_fail = 0;
  int           err_cnt = 0;
  int unsigned  div = 1;
  logic         pol = 1'b0;
  logic [47:0]  m_prev = '0;
  int           m_cnt = 0;
  line_timing_t held;
  vec_t         vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic line_timing_t dut_set();
    line_timing_t r;
    r.visible_area = visible_area;
    r.front_porch  = front_porch;
    r.sync_pulse   = sync_pulse;
    r.back_porch   = back_porch;
    r.polarity     = polarity;
    return r;
  endfunction

  always @(negedge clk) begin
    if (error === 1'b1) err_cnt++;
    if (period_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_period_done: got period_done=1 expected none pending (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("period_timing", 64'(dut_set()), 64'(mon_e.t));
        check("period_locked", 64'(locked), 64'(mon_e.locked));
      end
    end
  end

  task automatic step(input logic s_on, input logic d);
    sync_in = s_on ? pol : ~pol;
    de_in   = d;
    for (int unsigned k = 0; k < div; k++) begin
      tick = (k == div - 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int s, input int b, input int a, input int f);
    exp_t        e;
    logic [47:0] cur;
    cur = {12'(a), 12'(f), 12'(s), 12'(b)};
    if (cur == m_prev) m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
    else m_cnt = 1;
    m_prev = cur;
    e.t = {cur, pol};
    e.locked = (m_cnt >= 2);
    sb.push_back(e);
  endtask

  task automatic drive_period(input int s, input int b, input int a, input int f, input bit expect_done);
    for (int i = 0; i < s; i++) step(1'b1, 1'b0);
    for (int i = 0; i < b; i++) step(1'b0, 1'b0);
    for (int i = 0; i < a; i++) step(1'b0, 1'b1);
    for (int i = 0; i < f; i++) step(1'b0, 1'b0);
    if (expect_done) push_exp(s, b, a, f);
  endtask

  task automatic trailing_sync();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    sync_in = ~pol;
    de_in   = 1'b0;
    tick    = 1'b1;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_prev  = '0;
    m_cnt   = 0;
    err_cnt = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rst_timing"}, 64'(dut_set()), 64'(0));
    check({tag, "_rst_state"}, 64'(state), 64'(SYNC));
    check({tag, "_rst_flags"}, 64'({locked, period_done, error}), 64'(0));
  endtask

  initial begin
    vecs[0] = '{1'b0, 96, 48, 640, 16, 1, 4, 12'd640, 12'd16, 12'd96, 12'd48, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 44, 148, 1920, 88, 1, 3, 12'd1920, 12'd88, 12'd44, 12'd148, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 2, 33, 480, 10, 4, 3, 12'd480, 12'd10, 12'd2, 12'd33, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 10, 0, 50, 5, 1, 3, 12'd50, 12'd5, 12'd10, 12'd0, 1'b1, 1'b1};

    pol = 1'b0;
    div = 1;
    do_reset();
    check_reset_values("initial");

    foreach (vecs[r]) begin
      pol = vecs[r].pol;
      div = vecs[r].div;
      do_reset();
      for (int p = 0; p < vecs[r].periods; p++)
        drive_period(vecs[r].s, vecs[r].b, vecs[r].a, vecs[r].f, p > 0);
      trailing_sync();
      check($sformatf("row%0d_timing", r), 64'(dut_set()),
            64'({vecs[r].e_va, vecs[r].e_fp, vecs[r].e_sp, vecs[r].e_bp, vecs[r].e_pol}));
      check($sformatf("row%0d_locked", r), 64'(locked), 64'(vecs[r].e_lock));
      check($sformatf("row%0d_no_error", r), 64'(err_cnt), 64'(0));
    end

    // Front porch change while locked.
    pol = 1'b0;
    div = 1;
    do_reset();
    for (int p = 0; p < 3; p++) drive_period(96, 48, 640, 16, p > 0);
    drive_period(96, 48, 640, 20, 1'b1);
    drive_period(96, 48, 640, 20, 1'b1);
    check("fpchg_unlocked", 64'(locked), 64'(0));
    check("fpchg_fp20", 64'(front_porch), 64'(20));
    trailing_sync();
    check("fpchg_relocked", 64'(locked), 64'(1));

    // de asserted during sync.
    do_reset();
    for (int p = 0; p < 4; p++) drive_period(96, 48, 640, 16, p > 0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    held = dut_set();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    m_cnt = 0;
    check("viol_error_pulse", 64'(err_cnt), 64'(1));
    check("viol_unlocked", 64'(locked), 64'(0));
    check("viol_acquire", 64'(state), 64'(SYNC));
    check("viol_held", 64'(dut_set()), 64'(held));
    for (int i = 0; i < 53; i++) step(1'b1, 1'b0);
    drive_period(0, 48, 640, 16, 1'b0);
    drive_period(96, 48, 640, 16, 1'b1);
    check("viol_not_yet_locked", 64'(locked), 64'(0));
    drive_period(96, 48, 640, 16, 1'b1);
    trailing_sync();
    check("viol_relocked", 64'(locked), 64'(1));
    check("viol_single_error", 64'(err_cnt), 64'(1));

    // Reset pulse mid-ACTIVE.
    do_reset();
    for (int p = 0; p < 4; p++) drive_period(96, 48, 640, 16, p > 0);
    drive_period(96, 48, 300, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_prev = '0;
    m_cnt  = 0;
    check_reset_values("midrst");
    drive_period(0, 0, 340, 16, 1'b0);
    drive_period(96, 48, 640, 16, 1'b1);
    drive_period(96, 48, 640, 16, 1'b1);
    trailing_sync();
    check("midrst_relocked", 64'(locked), 64'(1));
    check("midrst_timing", 64'(dut_set()), 64'({12'd640, 12'd16, 12'd96, 12'd48, 1'b0}));

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
